serial_word_arbiter: RTL and testbench

- Shares one `serial_to_parallel` deserializer (LSB-first, `width` bits per word) between `n_chan` serial requesters.
- Grants one channel at a time for exactly one full word, then re-arbitrates, round-robin by default.
- Muxes the granted channel's bit stream onto the deserializer input.
- Emits a channel tag aligned with the deserializer's `parallel_valid`, so downstream logic knows which channel each word came from.

---
 rtl/serial_word_arbiter.sv | 146 ++++++++++++++
 tb/tb_serial_word_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_arbiter.sv
// serial_word_arbiter
// Shares one LSB-first serial_to_parallel deserializer between n_chan serial
// requesters. One channel is granted for exactly one full word. The arbiter
// then re-arbitrates with no bubble. A registered channel tag is emitted in
// the same cycle as the deserializer's parallel_valid.
//
// Build option: define SERIAL_ARB_FIXED_PRIO_EN to hold the round-robin
// pointer at 0, so the lowest-index requesting channel always wins. When the
// macro is undefined (the default), arbitration is round-robin.
module serial_word_arbiter #(
  parameter int n_chan = 4,
  parameter int width  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [n_chan-1:0]         req,
  output logic [n_chan-1:0]         grant,
  input  logic [n_chan-1:0]         ch_serial_valid,
  input  logic [n_chan-1:0]         ch_serial_data,
  output logic                      out_serial_valid,
  output logic                      out_serial_data,
  output logic                      tag_valid,
  output logic [$clog2(n_chan)-1:0] tag_chan,
  output logic                      busy,
  output logic                      stray_valid
);

  localparam int IDX_W = $clog2(n_chan);
  localparam int CNT_W = (width > 1) ? $clog2(width) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   arb_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic               accept;
  logic               last_bit;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [n_chan-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < n_chan; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [n_chan-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [n_chan-1:0] oh;
    oh = '0;
    for (int i = 0; i < n_chan; i++) begin
      if (int'(idx) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

`ifndef SERIAL_ARB_FIXED_PRIO_EN
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (int'(v) == n_chan - 1) ? '0 : v + IDX_W'(1);
  endfunction
`endif

  // Only the granted channel reaches the deserializer; grant is zero in IDLE.
  assign out_serial_valid = |(grant & ch_serial_valid);
  assign out_serial_data  = |(grant & ch_serial_data);

  assign accept   = (state == BUSY) && out_serial_valid;
  assign last_bit = accept && (cnt == CNT_W'(width - 1));
  assign gidx     = onehot_to_idx(grant);

`ifdef SERIAL_ARB_FIXED_PRIO_EN
  assign next_ptr = '0;
`else
  assign next_ptr = wrap_inc(gidx);
`endif

  // On the last bit the search starts just past the served channel, so a
  // re-asserted request from that channel competes at lowest priority.
  assign arb_ptr = last_bit ? next_ptr : ptr;

  // Winner: first requesting channel at arb_ptr, arb_ptr+1, ... mod n_chan.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < n_chan; i++) begin
      if (!win_found && req[(int'(arb_ptr) + i) % n_chan]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(arb_ptr) + i) % n_chan);
      end
    end
  end

  // Grant FSM, bit counter, pointer, tag and stray-valid registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      cnt         <= '0;
      ptr         <= '0;
      tag_valid   <= 1'b0;
      tag_chan    <= '0;
      stray_valid <= 1'b0;
    end else begin
      tag_valid   <= last_bit;
      stray_valid <= |(~grant & ch_serial_valid);
      if (last_bit) begin
        tag_chan <= gidx;
        ptr      <= next_ptr;
      end
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= idx_to_onehot(win_idx);
            busy  <= 1'b1;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            if (last_bit) begin
              cnt <= '0;
              if (win_found) begin
                grant <= idx_to_onehot(win_idx);
              end else begin
                grant <= '0;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_arbiter.sv
// Testbench for serial_word_arbiter: directed steps with a word scoreboard and
// a behavioural LSB-first deserializer that shares the arbiter's reset.
module tb_serial_word_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] ch_serial_valid;
  logic [N-1:0] ch_serial_data;
  logic         out_serial_valid;
  logic         out_serial_data;
  logic         tag_valid;
  logic [1:0]   tag_chan;
  logic         busy;
  logic         stray_valid;

  serial_word_arbiter #(.n_chan(N), .width(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .grant            (grant),
    .ch_serial_valid  (ch_serial_valid),
    .ch_serial_data   (ch_serial_data),
    .out_serial_valid (out_serial_valid),
    .out_serial_data  (out_serial_data),
    .tag_valid        (tag_valid),
    .tag_chan         (tag_chan),
    .busy             (busy),
    .stray_valid      (stray_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Channel model state
  logic [7:0]   word_q [N];
  int           bit_i  [N];
  logic [N-1:0] drv_mask;
  logic [N-1:0] stray_mask;
  logic         auto_drv;
  logic         stall;
  logic [9:0]   sb_q [$];

  // Behavioural deserializer
  logic [7:0]   d_sr;
  int           d_cnt;
  logic         pval;
  logic [7:0]   pword;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      d_sr  <= '0;
      d_cnt <= 0;
      pval  <= 1'b0;
      pword <= '0;
    end else begin
      pval <= 1'b0;
      if (out_serial_valid) begin
        d_sr <= {out_serial_data, d_sr[7:1]};
        if (d_cnt == W - 1) begin
          pval  <= 1'b1;
          pword <= {out_serial_data, d_sr[7:1]};
          d_cnt <= 0;
        end else begin
          d_cnt <= d_cnt + 1;
        end
      end
    end
  end

  // Scoreboard: every completed word must carry the expected tag and data.
  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (tag_valid || pval) begin
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = 'x;
      chk("tag_pval_align", {30'd0, tag_valid, pval}, 32'd3);
      chk("tag_chan", {30'd0, tag_chan}, {30'd0, e[9:8]});
      chk("deser_word", {24'd0, pword}, {24'd0, e[7:0]});
    end
  end

  // One cycle: account bits accepted last cycle, then drive the granted
  // channel's next bit plus any injected stray bits.
  task automatic cyc();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      if (drv_mask[c]) begin
        if (bit_i[c] == W - 1) begin
          bit_i[c]  = 0;
          word_q[c] = word_q[c] + 8'h11;
        end else begin
          bit_i[c]++;
        end
      end
    end
    drv_mask = '0;
    for (int c = 0; c < N; c++) begin
      if (grant[c] && auto_drv && !stall) begin
        drv_mask[c] = 1'b1;
        if (bit_i[c] == 0) sb_q.push_back({2'(c), word_q[c]});
      end
    end
    ch_serial_valid = drv_mask | stray_mask;
    for (int c = 0; c < N; c++) begin
      ch_serial_data[c] = drv_mask[c] ? word_q[c][bit_i[c]] : stray_mask[c];
    end
  endtask

  task automatic wait_tag(input int budget, output int n);
    n = 0;
    while (!tag_valid && n < budget) begin
      cyc();
      n++;
    end
    chk("tag_timeout", {31'd0, tag_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    cyc();
    cyc();
    sb_q.delete();
    for (int c = 0; c < N; c++) bit_i[c] = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n           = 1'b0;
    req             = '0;
    ch_serial_valid = '0;
    ch_serial_data  = '0;
    drv_mask        = '0;
    stray_mask      = '0;
    auto_drv        = 1'b1;
    stall           = 1'b0;
    for (int c = 0; c < N; c++) begin
      word_q[c] = '0;
      bit_i[c]  = 0;
    end

    // Reset values
    do_reset();
    cyc();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tag_valid", {31'd0, tag_valid}, 32'd0);
    chk("rst_tag_chan", {30'd0, tag_chan}, 32'd0);
    chk("rst_stray", {31'd0, stray_valid}, 32'd0);

    // Single word 0xA5 from channel 0
    word_q[0] = 8'hA5;
    req = 4'b0001;
    cyc();
    chk("single_grant", {28'd0, grant}, 32'h1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    wait_tag(20, n);
    chk("single_tag_lat", n, 32'd8);
    chk("single_tag_chan", {30'd0, tag_chan}, 32'd0);
    chk("single_grant_off", {28'd0, grant}, 32'd0);
    chk("single_busy_off", {31'd0, busy}, 32'd0);
    cyc();
    chk("single_tag_pulse", {31'd0, tag_valid}, 32'd0);

`ifndef SERIAL_ARB_FIXED_PRIO_EN
    // Round-robin under continuous requests and continuous valid
    do_reset();
    word_q[0] = 8'h3C; word_q[1] = 8'h96; word_q[2] = 8'h0F; word_q[3] = 8'hE1;
    req = 4'b1111;
    cyc();
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("rr_grant_%0d", i), {28'd0, grant}, 32'd1 << ((i / 8) % 4));
      if (i == 33) req = 4'b0000;
      cyc();
    end
    chk("rr_grant_end", {28'd0, grant}, 32'd0);
    chk("rr_busy_end", {31'd0, busy}, 32'd0);
    cyc();
`else
    // Fixed priority: channel 0 keeps winning over channel 2
    do_reset();
    word_q[0] = 8'h3C; word_q[2] = 8'h0F;
    req = 4'b0101;
    cyc();
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("fp_grant_%0d", i), {28'd0, grant}, 32'd1);
      if (i == 17) req = 4'b0000;
      cyc();
    end
    chk("fp_grant_end", {28'd0, grant}, 32'd0);
    cyc();
`endif

    // Stalls and a dropped request on channel 2
    word_q[2] = 8'hC3;
    req = 4'b0100;
    cyc();
    chk("stall_grant", {28'd0, grant}, 32'h4);
    cyc();
    req = 4'b0000;
    for (int i = 0; i < 3; i++) cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("stall_grant_held", {28'd0, grant}, 32'h4);
    chk("stall_busy_held", {31'd0, busy}, 32'd1);
    chk("stall_no_tag", {31'd0, tag_valid}, 32'd0);
    stall = 1'b0;
    wait_tag(20, n);
    chk("stall_tag_lat", 7 + n, 32'd11);
    chk("stall_tag_chan", {30'd0, tag_chan}, 32'd2);
    chk("stall_grant_off", {28'd0, grant}, 32'd0);
    cyc();

    // Stray bit during a channel 0 word, then reset mid-word
    word_q[0] = 8'h3A;
    req = 4'b0001;
    cyc();
    chk("stray_grant", {28'd0, grant}, 32'h1);
    cyc();
    stray_mask = 4'b0010;
    cyc();
    #1;
    chk("stray_out_valid", {31'd0, out_serial_valid}, 32'd1);
    chk("stray_out_data", {31'd0, out_serial_data}, 32'd0);
    stray_mask = '0;
    cyc();
    chk("stray_pulse", {31'd0, stray_valid}, 32'd1);
    cyc();
    chk("stray_clear", {31'd0, stray_valid}, 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    cyc();
    chk("b2b_grant", {28'd0, grant}, 32'h1);
    chk("b2b_tag", {31'd0, tag_valid}, 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    auto_drv = 1'b0;
    cyc();
    rst_n = 1'b0;
    req   = 4'b0000;
    cyc();
    chk("mid_rst_grant", {28'd0, grant}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_tag_valid", {31'd0, tag_valid}, 32'd0);
    chk("mid_rst_tag_chan", {30'd0, tag_chan}, 32'd0);
    chk("mid_rst_stray", {31'd0, stray_valid}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_serial_valid}, 32'd0);
    sb_q.delete();
    for (int c = 0; c < N; c++) bit_i[c] = 0;
    rst_n = 1'b1;
    auto_drv = 1'b1;
    word_q[0] = 8'h5A;
    req = 4'b0001;
    cyc();
    chk("post_rst_grant", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    wait_tag(20, n);
    chk("post_rst_tag_chan", {30'd0, tag_chan}, 32'd0);
    cyc();
    cyc();
    chk("sb_drain", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
